// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - instruction fetch stage with IF/ID pipeline register
module fetch_decode_stage #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_plus8,
    output logic               id_valid,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_id_instr;
    logic [PC_W-1:0]    r_id_pc;
    logic               r_id_valid;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [PC_W-1:0]    w_pc_plus4;
    logic [PC_W-1:0]    w_branch_pc;
    logic               w_cnt_max;

    assign w_pc_plus4  = r_pc + PC_W'(4);
    assign w_branch_pc = {branch_target[PC_W-1:2], 2'b00};
    assign w_cnt_max   = &r_stall_cnt;

    // Branch outranks stall: a redirect both flushes and consumes the cycle uncounted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= LP_RESET_PC;
            r_id_instr  <= '0;
            r_id_pc     <= '0;
            r_id_valid  <= 1'b0;
            r_stall_cnt <= '0;
        end else if (branch_taken) begin
            r_pc       <= w_branch_pc;
            r_id_instr <= '0;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (stall) begin
            if (!w_cnt_max) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end else begin
            r_id_instr <= imem_instr;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
            r_pc       <= w_pc_plus4;
        end
    end

    assign imem_addr   = r_pc;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus8 = r_id_pc + PC_W'(8);
    assign id_valid    = r_id_valid;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - scoreboard bench for fetch_decode_stage
module tb_fetch_decode_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] id_instr;
    logic [7:0]  id_pc;
    logic [7:0]  id_pc_plus8;
    logic        id_valid;
    logic [15:0] stall_cnt;

    fetch_decode_stage #(
        .PC_W(8), .INSTR_W(32), .RESET_PC(0), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus8(id_pc_plus8),
        .id_valid(id_valid), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];
    assign imem_instr = mem[imem_addr[7:2]];

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [7:0]  idpc;
        logic [7:0]  idpc8;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic [7:0]  m_idpc;
    logic        m_valid;
    logic [15:0] m_cnt;

    // Apply one cycle of inputs and push the state expected after the next posedge.
    task automatic step(input logic rst_n, input logic st, input logic br, input logic [7:0] tgt);
        exp_t e;
        reset = rst_n; stall = st; branch_taken = br; branch_target = tgt;
        if (!rst_n) begin
            m_pc = 8'd0; m_instr = 32'd0; m_idpc = 8'd0; m_valid = 1'b0; m_cnt = 16'd0;
        end else if (br) begin
            m_pc = tgt & 8'hFC; m_instr = 32'd0; m_idpc = 8'd0; m_valid = 1'b0;
        end else if (st) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_instr = mem[m_pc >> 2]; m_idpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 8'd4;
        end
        e.pc = m_pc; e.instr = m_instr; e.idpc = m_idpc;
        e.idpc8 = m_idpc + 8'd8; e.valid = m_valid; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (imem_addr !== e.pc || id_instr !== e.instr || id_pc !== e.idpc ||
                    id_pc_plus8 !== e.idpc8 || id_valid !== e.valid || stall_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL state t=%0t got addr=%h instr=%h pc=%h pc8=%h v=%b cnt=%h exp addr=%h instr=%h pc=%h pc8=%h v=%b cnt=%h",
                        $time, imem_addr, id_instr, id_pc, id_pc_plus8, id_valid, stall_cnt,
                        e.pc, e.instr, e.idpc, e.idpc8, e.valid, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        int waited;
        for (int i = 0; i < 64; i++) mem[i] = 32'hE1A00000 | i;
        mem[0] = 32'hE2110000;
        mem[1] = 32'hE0805183;
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;

        step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'h55);
        step(1, 0, 0, 8'h00);   // id_instr=E2110000, addr=4
        step(1, 0, 0, 8'h00);   // id_instr=E0805183, id_pc=4, plus8=12
        repeat (3) step(1, 1, 0, 8'h00);   // frozen at pc=8, cnt=3
        step(1, 0, 0, 8'h00);   // id_pc=8, pc=12
        step(1, 0, 0, 8'h00);   // pc=16
        step(1, 0, 1, 8'h27);   // addr=0x24, bubble
        step(1, 0, 0, 8'h00);   // id_pc=0x24
        step(1, 1, 1, 8'h41);   // branch wins, cnt stays 3
        step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'hF3);   // redirect to 0xF0
        repeat (5) step(1, 0, 0, 8'h00);   // pc wraps 252 -> 0, id_pc 248 -> plus8 0
        repeat (2) step(1, 1, 0, 8'h00);   // cnt=5
        step(0, 1, 0, 8'h00);   // reset during stall
        step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'h10);
        step(0, 0, 1, 8'h20);   // reset during branch
        step(1, 0, 0, 8'h00);
        repeat (65538) step(1, 1, 0, 8'h00);   // saturate at 0xFFFF
        step(1, 0, 0, 8'h00);
        step(1, 1, 0, 8'h00);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
